// File: rtl/sar_search_ctrl_if.sv
// Comparator handshake between the search engine and an external magnitude comparator.
//   guess       : candidate B operand, stable while guess_valid is high
//   guess_valid : engine is waiting for a verdict on guess
//   cmp_ack     : verdict valid this cycle (honoured only while guess_valid=1)
//   cmp_eq      : target == guess (wins over cmp_gt)
//   cmp_gt      : target > guess; eq=0/gt=0 means less-than
// master = search engine, slave = comparator.
interface sar_search_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             cmp_ack;
  logic             cmp_eq;
  logic             cmp_gt;

  modport master (
    output guess,
    output guess_valid,
    input  cmp_ack,
    input  cmp_eq,
    input  cmp_gt
  );

  modport slave (
    input  guess,
    input  guess_valid,
    output cmp_ack,
    output cmp_eq,
    output cmp_gt
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation (binary-search) engine: drives the B operand of an external
// comparator through the cmp interface and narrows [lo, hi] from its eq/gt verdicts.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : one-cycle search request, sampled only while idle
//   cmp        : comparator handshake (guess/guess_valid out, cmp_ack/cmp_eq/cmp_gt in)
//   busy       : search in progress (high through the final FIN cycle)
//   done       : one-cycle pulse when a search terminates
//   found      : last search hit equality, held until next start
//   result     : matched value or 0, held until next start
//   probes     : verdicts consumed by the last or current search
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  sar_search_ctrl_if.master     cmp,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [WIDTH-1:0]      result,
  output logic [CNT_W-1:0]      probes
);

  typedef enum logic [1:0] {StIdle, StCalc, StProbe, StFin} state_e;

  localparam logic [WIDTH:0]   BoundOne = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  // Bounds carry one extra bit so lo can step past the top of the range.
  logic [WIDTH:0]   lo_q, lo_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [CNT_W-1:0] probes_q, probes_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   mid_sum;
  logic [WIDTH:0]   guess_ext;

  // lo+hi never overflows WIDTH+1 bits whenever the midpoint is actually used (lo <= hi).
  assign mid_sum   = lo_q + hi_q;
  assign guess_ext = {1'b0, guess_q};

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    probes_d = probes_q;
    found_d  = found_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = {1'b0, {WIDTH{1'b1}}};
          probes_d = '0;
          found_d  = 1'b0;
          result_d = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        // Crossed bounds means the verdicts were inconsistent or exhausted the range.
        if (lo_q > hi_q) begin
          state_d = StFin;
        end else begin
          guess_d = mid_sum[WIDTH:1];
          state_d = StProbe;
        end
      end
      StProbe: begin
        if (cmp.cmp_ack) begin
          probes_d = probes_q + CntOne;
          if (cmp.cmp_eq) begin
            found_d  = 1'b1;
            result_d = guess_q;
            state_d  = StFin;
          end else if (cmp.cmp_gt) begin
            lo_d    = guess_ext + BoundOne;
            state_d = StCalc;
          end else if (guess_q == '0) begin
            // Less-than at zero: nothing below to search, hi left untouched.
            state_d = StFin;
          end else begin
            hi_d    = guess_ext - BoundOne;
            state_d = StCalc;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      probes_q <= '0;
      found_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      probes_q <= probes_d;
      found_q  <= found_d;
      result_q <= result_d;
    end
  end

  assign cmp.guess       = guess_q;
  assign cmp.guess_valid = (state_q == StProbe);
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StFin);
  assign found           = found_q;
  assign result          = result_q;
  assign probes          = probes_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: the bench plays the comparator, and an integer binary-search
// model predicts the probe sequence, outcome and cycle count of each search.
module tb_sar_search_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          found;
  logic [W-1:0]  result;
  logic [CW-1:0] probes;

  sar_search_ctrl_if #(.WIDTH(W)) cif ();

  sar_search_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp    (cif),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .result (result),
    .probes (probes)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observations of the most recent drive_search call.
  int obs_guesses[$];
  int obs_cycles, obs_done_cnt, obs_stall_err, obs_first_lat, obs_dly_sum;
  bit obs_timeout, obs_aborted;

  // Model outputs.
  int exp_guesses[$];
  int exp_n, exp_res, exp_extra;
  bit exp_found;

  // 0 = less-than, 1 = greater-than, 2 = equal. mode 0 honest, 1 always lt, 2 always gt.
  function automatic int verdict(input int target, input int mode, input int g);
    if (mode == 1) return 0;
    if (mode == 2) return 1;
    if (g == target) return 2;
    return (target > g) ? 1 : 0;
  endfunction

  // Plain integer binary search over 0..255; exp_extra is the cycles after the final
  // verdict's ack up to the done cycle (1 direct, 2 when the crossed-bounds check ends it).
  task automatic model(input int target, input int mode);
    int lo, hi, g, v;
    exp_guesses.delete();
    lo = 0; hi = 255; exp_n = 0; exp_found = 0; exp_res = 0; exp_extra = 1;
    while (1) begin
      if (lo > hi) begin exp_extra = 2; break; end
      g = (lo + hi) / 2;
      exp_guesses.push_back(g);
      exp_n++;
      v = verdict(target, mode, g);
      if (v == 2) begin exp_found = 1; exp_res = g; break; end
      if (v == 1) lo = g + 1;
      else if (g == 0) break;
      else hi = g - 1;
    end
  endtask

  task automatic drive_search(input int target, input int mode, input int dly, input bit rand_dly,
                              input bit noise, input int start_at, input int abort_at);
    int g, d, v, idx;
    bit fin;
    obs_guesses.delete();
    obs_done_cnt = 0; obs_stall_err = 0; obs_timeout = 0; obs_first_lat = -1;
    obs_dly_sum = 0; obs_aborted = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    obs_cycles = 1;
    fin = 0; idx = 0;
    while (!fin) begin
      if (obs_cycles > 600) begin
        obs_timeout = 1; fin = 1;
      end else if (done) begin
        obs_done_cnt++; fin = 1;
      end else if (cif.guess_valid) begin
        if (obs_first_lat < 0) obs_first_lat = obs_cycles;
        g = int'(cif.guess);
        obs_guesses.push_back(g);
        idx++;
        d = rand_dly ? int'($urandom_range(0, dly)) : dly;
        for (int k = 0; k < d; k++) begin
          cif.cmp_ack = 1'b0;
          cif.cmp_eq  = 1'($urandom_range(0, 1));
          cif.cmp_gt  = 1'($urandom_range(0, 1));
          if (idx == start_at && k == 0) start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          obs_cycles++; obs_dly_sum++;
          if (cif.guess !== 8'(g) || cif.guess_valid !== 1'b1 || busy !== 1'b1) obs_stall_err++;
          if (idx == abort_at && k == 1) begin
            rst_n = 1'b0;
            obs_aborted = 1;
            return;
          end
        end
        v = verdict(target, mode, g);
        cif.cmp_ack = 1'b1;
        cif.cmp_eq  = (v == 2);
        cif.cmp_gt  = (v == 1) || (v == 2 && $urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        obs_cycles++;
        cif.cmp_ack = 1'b0;
      end else begin
        // Verdicts offered while no guess is pending must be ignored.
        cif.cmp_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cif.cmp_eq  = 1'($urandom_range(0, 1));
        cif.cmp_gt  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        obs_cycles++;
        cif.cmp_ack = 1'b0;
      end
    end
    if (!obs_timeout) begin
      @(posedge clk); #1;
      if (done) obs_done_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cif.guess_valid !== 1'b0) begin errors++;
      $display("FAIL reset_flags busy=%b done=%b gv=%b want 0 0 0", busy, done, cif.guess_valid); end
    checks++; if (found !== 1'b0 || result !== 8'd0 || probes !== 4'd0 || cif.guess !== 8'd0) begin
      errors++; $display("FAIL reset_regs found=%b result=%0d probes=%0d guess=%0d want 0",
                         found, result, probes, cif.guess); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL idle_after_reset busy=%b want 0", busy); end
  endtask

  task automatic test_directed();
    int tbl_t[5] = '{100, 255, 0, 0, 0};
    int tbl_m[5] = '{0, 0, 0, 1, 2};
    int tbl_n[5] = '{8, 9, 8, 8, 9};
    int tbl_f[5] = '{1, 1, 1, 0, 0};
    int tbl_r[5] = '{100, 255, 0, 0, 0};
    int tbl_x[5] = '{1, 1, 1, 1, 2};
    int tbl_g[5][9] = '{'{127, 63, 95, 111, 103, 99, 101, 100, 0},
                        '{127, 191, 223, 239, 247, 251, 253, 254, 255},
                        '{127, 63, 31, 15, 7, 3, 1, 0, 0},
                        '{127, 63, 31, 15, 7, 3, 1, 0, 0},
                        '{127, 191, 223, 239, 247, 251, 253, 254, 255}};
    for (int e = 0; e < 5; e++) begin
      drive_search(tbl_t[e], tbl_m[e], 0, 0, 0, 0, 0);
      checks++; if (obs_timeout) begin errors++;
        $display("FAIL dir%0d_timeout no done within bound", e); end
      checks++; if (obs_guesses.size() != tbl_n[e]) begin errors++;
        $display("FAIL dir%0d_nguess got %0d want %0d", e, obs_guesses.size(), tbl_n[e]); end
      for (int i = 0; i < tbl_n[e] && i < obs_guesses.size(); i++) begin
        checks++; if (obs_guesses[i] != tbl_g[e][i]) begin errors++;
          $display("FAIL dir%0d_guess%0d got %0d want %0d", e, i, obs_guesses[i], tbl_g[e][i]); end
      end
      checks++; if (found !== 1'(tbl_f[e]) || result !== 8'(tbl_r[e])) begin errors++;
        $display("FAIL dir%0d_outcome found=%b result=%0d want %0d %0d", e, found, result,
                 tbl_f[e], tbl_r[e]); end
      checks++; if (probes !== 4'(tbl_n[e])) begin errors++;
        $display("FAIL dir%0d_probes got %0d want %0d", e, probes, tbl_n[e]); end
      checks++; if (obs_done_cnt != 1) begin errors++;
        $display("FAIL dir%0d_done_pulses got %0d want 1", e, obs_done_cnt); end
      checks++; if (obs_first_lat != 2) begin errors++;
        $display("FAIL dir%0d_first_latency got %0d want 2", e, obs_first_lat); end
      checks++; if (obs_cycles != 2 * tbl_n[e] + tbl_x[e]) begin errors++;
        $display("FAIL dir%0d_cycles got %0d want %0d", e, obs_cycles, 2 * tbl_n[e] + tbl_x[e]); end
      checks++; if (busy !== 1'b0) begin errors++;
        $display("FAIL dir%0d_busy_after got %b want 0", e, busy); end
    end
  endtask

  // Random targets, modes, ack delays and spurious acks; each search starts the cycle
  // after the previous one returns to idle.
  task automatic test_back_to_back();
    int t, m, r;
    for (int it = 0; it < 12; it++) begin
      t = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 5));
      m = (r < 4) ? 0 : r - 3;
      model(t, m);
      drive_search(t, m, 3, 1, 1, 0, 0);
      checks++; if (obs_timeout) begin errors++;
        $display("FAIL rnd%0d_timeout target=%0d mode=%0d", it, t, m); end
      checks++; if (obs_guesses != exp_guesses) begin errors++;
        $display("FAIL rnd%0d_sequence target=%0d mode=%0d got %p want %p", it, t, m,
                 obs_guesses, exp_guesses); end
      checks++; if (found !== exp_found || result !== 8'(exp_res) || probes !== 4'(exp_n)) begin
        errors++; $display("FAIL rnd%0d_outcome found=%b result=%0d probes=%0d want %b %0d %0d",
                           it, found, result, probes, exp_found, exp_res, exp_n); end
      checks++; if (obs_cycles != 2 * exp_n + obs_dly_sum + exp_extra) begin errors++;
        $display("FAIL rnd%0d_cycles got %0d want %0d", it, obs_cycles,
                 2 * exp_n + obs_dly_sum + exp_extra); end
      checks++; if (obs_stall_err != 0 || obs_done_cnt != 1) begin errors++;
        $display("FAIL rnd%0d_handshake stall_err=%0d done_pulses=%0d want 0 1", it,
                 obs_stall_err, obs_done_cnt); end
    end
  endtask

  task automatic test_stall_reset();
    int bad_done;
    model(45, 0);
    // Start pulse during probe 2's stall, reset during probe 4's stall.
    drive_search(45, 0, 3, 0, 0, 2, 4);
    #1;
    checks++; if (!obs_aborted || obs_guesses.size() != 4) begin errors++;
      $display("FAIL sr_abort_point aborted=%b nguess=%0d want 1 4", obs_aborted,
               obs_guesses.size()); end
    for (int i = 0; i < 4 && i < obs_guesses.size(); i++) begin
      checks++; if (obs_guesses[i] != exp_guesses[i]) begin errors++;
        $display("FAIL sr_guess%0d got %0d want %0d", i, obs_guesses[i], exp_guesses[i]); end
    end
    checks++; if (obs_stall_err != 0) begin errors++;
      $display("FAIL sr_stall_stable errors=%0d want 0", obs_stall_err); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cif.guess_valid !== 1'b0 ||
                  cif.guess !== 8'd0 || found !== 1'b0 || result !== 8'd0 || probes !== 4'd0) begin
      errors++; $display("FAIL sr_async_reset busy=%b done=%b gv=%b guess=%0d found=%b res=%0d pr=%0d want 0",
                         busy, done, cif.guess_valid, cif.guess, found, result, probes); end
    bad_done = obs_done_cnt;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) bad_done++;
    end
    checks++; if (bad_done != 0) begin errors++;
      $display("FAIL sr_no_done got %0d done cycles want 0", bad_done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_search(45, 0, 3, 0, 0, 0, 0);
    checks++; if (obs_timeout || found !== 1'b1 || result !== 8'd45 || probes !== 4'(exp_n)) begin
      errors++; $display("FAIL sr_fresh_search to=%b found=%b result=%0d probes=%0d want 0 1 45 %0d",
                         obs_timeout, found, result, probes, exp_n); end
    checks++; if (obs_guesses != exp_guesses || obs_stall_err != 0 || obs_done_cnt != 1) begin
      errors++; $display("FAIL sr_fresh_handshake got %p stall_err=%0d done=%0d want %p 0 1",
                         obs_guesses, obs_stall_err, obs_done_cnt, exp_guesses); end
  endtask

  initial begin
    cif.cmp_ack = 1'b0;
    cif.cmp_eq  = 1'b0;
    cif.cmp_gt  = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Sequential successive-approximation (binary-search) engine that drives the B operand of an external WIDTH-bit magnitude comparator and consumes its eq/gt flags.
- Finds an unknown WIDTH-bit target in at most WIDTH+1 probes.
- Used to recover a hidden byte, e.g. a key-byte oracle, from comparator verdicts alone.
- The comparator is external and may take any number of cycles to respond; a valid/ack handshake covers that.

Parameters:
- WIDTH, 8, operand width; search range is 0 .. 2^WIDTH-1.
- CNT_W, 4, probe-counter width; must satisfy 2^CNT_W > WIDTH+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a search; sampled only in IDLE.
- guess  output  WIDTH  candidate value presented to the comparator.
- guess_valid  output  1  guess is stable and awaiting a verdict.
- cmp_ack  input  1  verdict valid this cycle; honoured only while guess_valid=1.
- cmp_eq  input  1  target == guess.
- cmp_gt  input  1  target > guess; with cmp_eq=0 and cmp_gt=0 the verdict is "less than".
- busy  output  1  search in progress (state not IDLE).
- done  output  1  one-cycle pulse when the search terminates.
- found  output  1  last search hit equality; held until the next start.
- result  output  WIDTH  matched value, or 0 if not found; held until the next start.
- probes  output  CNT_W  number of verdicts consumed by the last or current search.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - guess=0, guess_valid=0, busy=0, done=0, found=0, result=0, probes=0.
  - lo=0, hi=0.
  - Reset mid-search abandons the search immediately; no done pulse is generated.
- Bounds: lo and hi are held in WIDTH+1 bits. Midpoint = (lo+hi)>>1, computed on a WIDTH+1-bit sum and truncated to WIDTH bits.
- IDLE:
  - On start=1: lo<=0, hi<=2^WIDTH-1, probes<=0, found<=0, result<=0; go to CALC.
- CALC (1 cycle, guess_valid=0):
  - If lo>hi: go to FIN with found=0.
  - Else: guess<=midpoint; go to PROBE.
- PROBE:
  - guess_valid=1 and guess is held stable until cmp_ack.
  - Stall indefinitely while cmp_ack=0.
  - On cmp_ack=1: probes<=probes+1, then:
    - cmp_eq=1: found<=1, result<=guess; go to FIN. cmp_eq has priority over cmp_gt; eq and gt together is treated as eq.
    - cmp_gt=1: lo<=guess+1 (in WIDTH+1 bits, so guess=2^WIDTH-1 yields lo=2^WIDTH); go to CALC.
    - less-than with guess=0: go to FIN with found=0. This is underflow; hi is not modified.
    - less-than otherwise: hi<=guess-1; go to CALC.
- FIN (1 cycle): done=1, guess_valid=0; go to IDLE. busy is high through FIN and falls with it.
- Timing:
  - First guess is visible with guess_valid=1 two cycles after start is sampled.
  - Each non-terminal verdict costs ack cycle + 1 CALC cycle before the next probe.
- start while busy=1 is ignored; no queuing.
- cmp_ack while guess_valid=0 is ignored.
- A consistent comparator always terminates within WIDTH+1 probes. Inconsistent verdicts terminate with found=0 through the lo>hi check or the underflow rule.

Test Plan:
- Target 100, zero-latency ack -> guesses 127,63,95,111,103,99,101,100; found=1, result=100, probes=8; done pulses once.
- Target 255 -> guesses 127,191,223,239,247,251,253,254,255; found=1, probes=9.
- Target 0 -> guesses 127,63,31,15,7,3,1,0; found=1, result=0, probes=8.
- Adversarial comparator that always answers less-than -> ends after guess 0 with found=0, result=0, probes=8.
- Adversarial comparator that always answers gt -> lo reaches 256 after guess 255; found=0, probes=9.
- Target 45 with cmp_ack delayed 3 cycles per probe, a start pulse mid-search, then rst_n low during the 4th probe:
  - Stalls: guess stable and guess_valid high throughout every stall.
  - Mid-search start: ignored.
  - Reset: all outputs 0 immediately and no done pulse.
  - A fresh start after reset finds 45.
